// File: rtl/apb_bridge_ctrl.sv
// ----------------------------------------------------------------------------
// apb_bridge_ctrl
//
// AHB-Lite slave to APB master bridge. One AHB transfer at a time is turned
// into an APB SETUP/ACCESS sequence on the slave picked by the address field
// haddr[SLV_LSB +: SLV_W]. Unmapped slave indices and APB slave errors are
// answered with the two-cycle AHB ERROR response. All outputs are registered.
//
// Optional feature: define APB_TIMEOUT_EN to abort an APB access after
// TIMEOUT consecutive ACCESS cycles without pready (answered as ERROR).
// Without the macro the bridge waits for pready indefinitely.
//
// Ports
//   hclk, hresetn              clock, asynchronous active-low reset
//   hsel, htrans, hwrite,
//   haddr, hwdata, hready_in   AHB-Lite request side
//   hreadyout, hresp, hrdata   AHB-Lite response side (hresp: 0 OKAY, 1 ERROR)
//   paddr, pwdata, pwrite,
//   psel (one-hot), penable    APB request side
//   prdata, pready, pslverr    APB response side (prdata muxed externally)
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no transfer; zero-wait OKAY, samples new AHB transfers
// WDATA  | write data phase; hwdata captured into pwdata on exit
// SETUP  | APB setup: psel asserted, penable low
// ACCESS | APB access: penable high, waiting for pready
// ERR1   | first ERROR cycle (hreadyout low)
// ERR2   | second ERROR cycle (hreadyout high)
// ----------------------------------------------------------------------------
module apb_bridge_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NSLV    = 4,
    parameter int SLV_LSB = 24,
    parameter int TIMEOUT = 16
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              hsel,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [DATA_W-1:0] hwdata,
    input  logic              hready_in,
    output logic              hreadyout,
    output logic              hresp,
    output logic [DATA_W-1:0] hrdata,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              pwrite,
    output logic [NSLV-1:0]   psel,
    output logic              penable,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int SLV_W = (NSLV > 1) ? $clog2(NSLV) : 1;
    // The decoder looks at up to a full byte above SLV_LSB so that addresses
    // aliasing above the populated slaves (e.g. index 5 with 4 slaves) are
    // reported as unmapped instead of wrapping onto a real slave.
    localparam int DEC_W = ((ADDR_W - SLV_LSB) < 8) ? (ADDR_W - SLV_LSB) : 8;
    localparam logic [31:0] NSLV_U = 32'(NSLV);

    if (NSLV < 1 || NSLV > 8 || TIMEOUT < 1 || DEC_W < SLV_W) begin : g_bad_param
        $error("apb_bridge_ctrl: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WDATA  = 3'd1,
        S_SETUP  = 3'd2,
        S_ACCESS = 3'd3,
        S_ERR1   = 3'd4,
        S_ERR2   = 3'd5
    } state_t;

    state_t state;
    state_t state_n;

    logic [SLV_W-1:0]  idx_q;
    logic [SLV_W-1:0]  idx_n;
    logic [DEC_W-1:0]  dec_idx;
    logic              idx_ok;
    logic              valid;
    logic              accept;
    logic              to_hit;

    logic              hreadyout_n;
    logic              hresp_n;
    logic [DATA_W-1:0] hrdata_n;
    logic [ADDR_W-1:0] paddr_n;
    logic [DATA_W-1:0] pwdata_n;
    logic              pwrite_n;
    logic [NSLV-1:0]   psel_n;
    logic              penable_n;

    assign valid   = hsel & htrans[1] & hready_in;
    assign accept  = (state == S_IDLE) && valid;
    assign dec_idx = haddr[SLV_LSB +: DEC_W];
    assign idx_ok  = ({{(32-DEC_W){1'b0}}, dec_idx} < NSLV_U);
    assign idx_n   = accept ? dec_idx[SLV_W-1:0] : idx_q;

`ifdef APB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt;

    // Counts ACCESS cycles that ended without pready; fires on the cycle
    // that would make the count reach TIMEOUT.
    assign to_hit = (state == S_ACCESS) && !pready && (to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            to_cnt <= '0;
        end else if (state_n == S_SETUP) begin
            to_cnt <= '0;
        end else if (state == S_ACCESS && !pready) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= S_IDLE;
            idx_q     <= '0;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
            hrdata    <= '0;
            paddr     <= '0;
            pwdata    <= '0;
            pwrite    <= 1'b0;
            psel      <= '0;
            penable   <= 1'b0;
        end else begin
            state     <= state_n;
            idx_q     <= idx_n;
            hreadyout <= hreadyout_n;
            hresp     <= hresp_n;
            hrdata    <= hrdata_n;
            paddr     <= paddr_n;
            pwdata    <= pwdata_n;
            pwrite    <= pwrite_n;
            psel      <= psel_n;
            penable   <= penable_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (valid) begin
                    if (!idx_ok)     state_n = S_ERR1;
                    else if (hwrite) state_n = S_WDATA;
                    else             state_n = S_SETUP;
                end
            end
            S_WDATA:  state_n = S_SETUP;
            S_SETUP:  state_n = S_ACCESS;
            S_ACCESS: begin
                if (pready)      state_n = pslverr ? S_ERR1 : S_IDLE;
                else if (to_hit) state_n = S_ERR1;
            end
            S_ERR1:   state_n = S_ERR2;
            S_ERR2:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Output logic: values the registers take on entering state_n
    always_comb begin
        hreadyout_n = 1'b1;
        hresp_n     = 1'b0;
        psel_n      = '0;
        penable_n   = 1'b0;
        hrdata_n    = hrdata;
        paddr_n     = accept ? haddr  : paddr;
        pwrite_n    = accept ? hwrite : pwrite;
        pwdata_n    = (state == S_WDATA) ? hwdata : pwdata;

        if (state == S_ACCESS && pready && !pslverr && !pwrite) begin
            hrdata_n = prdata;
        end

        case (state_n)
            S_IDLE: begin
                hreadyout_n = 1'b1;
            end
            S_WDATA: begin
                hreadyout_n = 1'b0;
            end
            S_SETUP: begin
                hreadyout_n = 1'b0;
                psel_n      = NSLV'(1) << idx_n;
            end
            S_ACCESS: begin
                hreadyout_n = 1'b0;
                psel_n      = psel;
                penable_n   = 1'b1;
            end
            S_ERR1: begin
                hreadyout_n = 1'b0;
                hresp_n     = 1'b1;
            end
            S_ERR2: begin
                hreadyout_n = 1'b1;
                hresp_n     = 1'b1;
            end
            default: begin
                hreadyout_n = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_bridge_ctrl.sv
// ----------------------------------------------------------------------------
// tb_apb_bridge_ctrl
//
// Directed bench for apb_bridge_ctrl. The driver issues AHB transfers and
// pushes the hand-computed AHB response and APB request it expects into two
// queues; an independent monitor pops and compares whenever the DUT starts an
// APB setup phase or completes an AHB response. A small APB slave model
// inserts a programmable number of wait states and drives junk prdata with
// pslverr=1 while pready is low.
// ----------------------------------------------------------------------------
module tb_apb_bridge_ctrl;

    logic        hclk;
    logic        hresetn;
    logic        hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hready_in;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic [3:0]  psel;
    logic        penable;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    apb_bridge_ctrl #(
        .ADDR_W (32),
        .DATA_W (32),
        .NSLV   (4),
        .SLV_LSB(24),
        .TIMEOUT(16)
    ) dut (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .hsel     (hsel),
        .htrans   (htrans),
        .hwrite   (hwrite),
        .haddr    (haddr),
        .hwdata   (hwdata),
        .hready_in(hready_in),
        .hreadyout(hreadyout),
        .hresp    (hresp),
        .hrdata   (hrdata),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .pwrite   (pwrite),
        .psel     (psel),
        .penable  (penable),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr)
    );

    typedef struct {
        logic        hresp;
        logic [31:0] hrdata;
        int          acc;
        int          lat;
    } resp_t;

    typedef struct {
        logic [3:0]  psel;
        logic [31:0] paddr;
        logic        pwrite;
        logic [31:0] pwdata;
        int          acc_len;
    } apb_t;

    resp_t rq[$];
    apb_t  aq[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int          sl_waits = 0;
    logic        sl_err   = 1'b0;
    logic [31:0] sl_rdata = '0;

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    always @(posedge hclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // APB slave model
    initial begin
        int wcnt;
        wcnt    = 0;
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
        forever begin
            @(negedge hclk);
            if (psel != 4'b0 && penable) begin
                if (wcnt >= sl_waits) begin
                    pready  = 1'b1;
                    pslverr = sl_err;
                    prdata  = sl_rdata;
                end else begin
                    pready  = 1'b0;
                    pslverr = 1'b1;
                    prdata  = 32'hDEAD_DEAD;
                end
                wcnt++;
            end else begin
                pready  = 1'b0;
                pslverr = 1'b0;
                prdata  = 32'h0;
                wcnt    = 0;
            end
        end
    end

    // Monitor / scoreboard
    resp_t       mon_r;
    apb_t        mon_a;
    logic        prev_hrdy  = 1'b1;
    logic        prev_hresp = 1'b0;
    logic [3:0]  prev_psel  = '0;
    logic [31:0] prev_paddr = '0;
    logic        prev_pen   = 1'b0;
    logic        active     = 1'b0;
    int          acc_cnt    = 0;
    int          exp_acc    = 0;

    initial begin
        forever begin
            @(negedge hclk);
            if (!hresetn) begin
                prev_hrdy  = 1'b1;
                prev_hresp = 1'b0;
                prev_psel  = '0;
                prev_paddr = '0;
                prev_pen   = 1'b0;
                active     = 1'b0;
            end else begin
                if (hreadyout && !prev_hrdy) begin
                    if (rq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp hresp=%0b required=none", hresp);
                    end else begin
                        mon_r = rq.pop_front();
                        check("resp_hresp", 64'(hresp), 64'(mon_r.hresp));
                        if (mon_r.hresp) check("resp_err1_phase", 64'(prev_hresp), 64'd1);
                        check("resp_hrdata", 64'(hrdata), 64'(mon_r.hrdata));
                        check("resp_latency", 64'(cyc - mon_r.acc + 1), 64'(mon_r.lat));
                    end
                end
                if (psel != 4'b0 && !penable && prev_psel == 4'b0) begin
                    if (aq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_psel psel=%0h required=0", psel);
                    end else begin
                        mon_a = aq.pop_front();
                        check("setup_psel", 64'(psel), 64'(mon_a.psel));
                        check("setup_paddr", 64'(paddr), 64'(mon_a.paddr));
                        check("setup_pwrite", 64'(pwrite), 64'(mon_a.pwrite));
                        if (mon_a.pwrite) check("setup_pwdata", 64'(pwdata), 64'(mon_a.pwdata));
                        acc_cnt = 0;
                        exp_acc = mon_a.acc_len;
                        active  = 1'b1;
                    end
                end
                if (penable) begin
                    acc_cnt++;
                    check("access_psel_stable", 64'(psel), 64'(prev_psel));
                    check("access_paddr_stable", 64'(paddr), 64'(prev_paddr));
                end
                if (active && prev_pen && !penable) begin
                    if (exp_acc >= 0) check("access_cycles", 64'(acc_cnt), 64'(exp_acc));
                    check("psel_released", 64'(psel), 64'd0);
                    active = 1'b0;
                end
                prev_hrdy  = hreadyout;
                prev_hresp = hresp;
                prev_psel  = psel;
                prev_paddr = paddr;
                prev_pen   = penable;
            end
        end
    end

    // Issue one AHB transfer at a negedge; returns at the negedge where
    // hreadyout is high again (or right after the data phase if no response
    // is expected).
    task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int waits, input logic err,
                           input logic use_apb, input logic [3:0] e_psel, input int e_acc,
                           input logic use_resp, input logic e_hresp, input logic [31:0] e_hrdata,
                           input int e_lat);
        resp_t r;
        apb_t  a;
        int    n;
        sl_waits  = waits;
        sl_err    = err;
        sl_rdata  = rdata;
        hsel      = 1'b1;
        htrans    = 2'b10;
        hwrite    = wr;
        haddr     = addr;
        hready_in = 1'b1;
        if (use_apb) begin
            a.psel = e_psel; a.paddr = addr; a.pwrite = wr; a.pwdata = wdata; a.acc_len = e_acc;
            aq.push_back(a);
        end
        if (use_resp) begin
            r.hresp = e_hresp; r.hrdata = e_hrdata; r.acc = cyc + 1; r.lat = e_lat;
            rq.push_back(r);
        end
        @(posedge hclk);
        @(negedge hclk);
        hsel   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        haddr  = 32'h0;
        hwdata = wdata;
        if (use_resp) begin
            n = 0;
            while (!hreadyout && n < 200) begin
                @(negedge hclk);
                n++;
            end
            if (n >= 200) begin
                checks++;
                errors++;
                $display("FAIL wait_hreadyout actual=timeout required=completion");
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_hreadyout"}, 64'(hreadyout), 64'd1);
        check({tag, "_hresp"}, 64'(hresp), 64'd0);
        check({tag, "_psel"}, 64'(psel), 64'd0);
        check({tag, "_penable"}, 64'(penable), 64'd0);
        check({tag, "_pwrite"}, 64'(pwrite), 64'd0);
        check({tag, "_paddr"}, 64'(paddr), 64'd0);
        check({tag, "_pwdata"}, 64'(pwdata), 64'd0);
        check({tag, "_hrdata"}, 64'(hrdata), 64'd0);
    endtask

    // No-transfer patterns: {hsel, htrans, hready_in}
    logic [3:0] idle_pat [4] = '{4'b1_00_1, 4'b1_01_1, 4'b0_10_1, 4'b1_10_0};

    initial begin
        hresetn   = 1'b1;
        hsel      = 1'b0;
        htrans    = 2'b00;
        hwrite    = 1'b0;
        haddr     = 32'h0;
        hwdata    = 32'h0;
        hready_in = 1'b1;
        #3 hresetn = 1'b0;
        #1 check_reset_values("rst_init");
        repeat (2) @(negedge hclk);
        #2 hresetn = 1'b1;
        @(negedge hclk);

        // No APB activity, zero-wait OKAY for non-transfers
        for (int i = 0; i < 4; i++) begin
            hsel      = idle_pat[i][3];
            htrans    = idle_pat[i][2:1];
            hready_in = idle_pat[i][0];
            hwrite    = 1'b0;
            haddr     = 32'h0100_0000;
            repeat (2) begin
                @(negedge hclk);
                check("idle_hreadyout", 64'(hreadyout), 64'd1);
                check("idle_psel", 64'(psel), 64'd0);
                check("idle_hresp", 64'(hresp), 64'd0);
            end
        end
        hsel = 1'b0; htrans = 2'b00; hready_in = 1'b1; haddr = 32'h0;
        @(negedge hclk);

        // Read slave 1, no wait
        do_xfer(1'b0, 32'h0100_0010, 32'h0, 32'hCAFE_F00D, 0, 1'b0,
                1'b1, 4'b0010, 1, 1'b1, 1'b0, 32'hCAFE_F00D, 3);
        // Write slave 2, two wait states; hrdata holds
        do_xfer(1'b1, 32'h0200_0004, 32'h1234_5678, 32'h0, 2, 1'b0,
                1'b1, 4'b0100, 3, 1'b1, 1'b0, 32'hCAFE_F00D, 6);
        // Back-to-back reads, slaves 0 and 3
        do_xfer(1'b0, 32'h0000_0020, 32'h0, 32'hA5A5_0001, 0, 1'b0,
                1'b1, 4'b0001, 1, 1'b1, 1'b0, 32'hA5A5_0001, 3);
        do_xfer(1'b0, 32'h0300_0008, 32'h0, 32'h5A5A_0002, 0, 1'b0,
                1'b1, 4'b1000, 1, 1'b1, 1'b0, 32'h5A5A_0002, 3);
        // Write slave 1, no wait
        do_xfer(1'b1, 32'h0100_0100, 32'hDEAD_BEEF, 32'h0, 0, 1'b0,
                1'b1, 4'b0010, 1, 1'b1, 1'b0, 32'h5A5A_0002, 4);
        // Read with slave error: ERR1/ERR2, hrdata holds
        do_xfer(1'b0, 32'h0000_0040, 32'h0, 32'h1111_2222, 0, 1'b1,
                1'b1, 4'b0001, 1, 1'b1, 1'b1, 32'h5A5A_0002, 4);
        @(negedge hclk);
        // Unmapped slave index 5
        do_xfer(1'b0, 32'h0500_0000, 32'h0, 32'h0, 0, 1'b0,
                1'b0, 4'b0000, 0, 1'b1, 1'b1, 32'h5A5A_0002, 2);
        @(negedge hclk);
        // Read with 3 waits; junk prdata / pslverr=1 during waits ignored
        do_xfer(1'b0, 32'h0200_0010, 32'h0, 32'h7777_8888, 3, 1'b0,
                1'b1, 4'b0100, 4, 1'b1, 1'b0, 32'h7777_8888, 6);

`ifdef APB_TIMEOUT_EN
        // Timeout after 16 ACCESS cycles
        do_xfer(1'b0, 32'h0300_0000, 32'h0, 32'h0, 1000, 1'b0,
                1'b1, 4'b1000, 16, 1'b1, 1'b1, 32'h7777_8888, 19);
        @(negedge hclk);
`endif

        // Stuck access, then asynchronous reset in ACCESS
        do_xfer(1'b0, 32'h0300_0004, 32'h0, 32'h0, 1000, 1'b0,
                1'b1, 4'b1000, -1, 1'b0, 1'b0, 32'h0, 0);
`ifdef APB_TIMEOUT_EN
        repeat (5) @(negedge hclk);
`else
        repeat (100) @(negedge hclk);
`endif
        check("stuck_psel", 64'(psel), 64'h8);
        check("stuck_penable", 64'(penable), 64'd1);
        check("stuck_hreadyout", 64'(hreadyout), 64'd0);
        #2 hresetn = 1'b0;
        #1 check_reset_values("rst_mid");
        @(negedge hclk);
        #2 hresetn = 1'b1;
        @(negedge hclk);

        // Normal read after reset
        do_xfer(1'b0, 32'h0100_0020, 32'h0, 32'h2468_ACE0, 0, 1'b0,
                1'b1, 4'b0010, 1, 1'b1, 1'b0, 32'h2468_ACE0, 3);
        repeat (3) @(negedge hclk);

        check("resp_queue_empty", 64'(rq.size()), 64'd0);
        check("apb_queue_empty", 64'(aq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
